uart_pixel_loader: RTL
======================

// Module: uart_pixel_loader
// PURPOSE
//  Sits between the UART receiver and the image frame-buffer BRAM. Packs the received byte stream
//  into 12-bit RGB444 pixels (3 bytes -> 2 pixels) and drives the BRAM write port with sequential addresses.
//  Signals frame completion and recovers from line errors or a stalled host by resynchronising.
// PARAMETERS
//  ADDR_W      17        BRAM address width
//  NUM_PIXELS  76800     pixels per frame; must be even and <= 2**ADDR_W
//  TIMEOUT_CYC 1_000_000 idle clk cycles allowed mid-group before the partial group is dropped
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  rst        in   1       asynchronous, active-high reset
//  rx_data    in   8       byte from UART RX
//  rx_valid   in   1       1-cycle strobe: rx_data valid
//  rx_err     in   1       1-cycle strobe: framing/parity error on the current byte
//  mem_addr   out  ADDR_W  BRAM write address
//  mem_data   out  12      BRAM write data {R[3:0],G[3:0],B[3:0]}
//  mem_we     out  1       BRAM write enable, 1-cycle pulse
//  frame_done out  1       1-cycle pulse with the final pixel write of a frame
//  busy       out  1       high while a frame is partially loaded (mem_addr != 0 or group in progress)
//  err_sticky out  1       set by rx_err or timeout; cleared only by rst
// BEHAVIOUR
//  Reset: all outputs 0, state S_B0 (S_SYNC with macro), pixel address 0, timeout counter 0.
//  FSM: S_B0 -> S_B1 -> S_B2 -> S_B0, advancing only on rx_valid && !rx_err.
//   S_B0: latch b0.  S_B1: latch b1; write pixel A = {b0, b1[7:4]}.  S_B2: write pixel B = {b1[3:0], rx_data}.
//  Latency: mem_we asserted the cycle after the rx_valid that completes a pixel (registered outputs).
//  Address: each write uses the current pixel address, then increments; after the write at NUM_PIXELS-1 the
//   address wraps to 0 and frame_done pulses in the same cycle as that mem_we.
//  rx_err (with or without rx_valid): byte discarded, partial group dropped, FSM -> S_B0 (S_SYNC with macro),
//   pixel address NOT reset unless in S_SYNC flow; err_sticky <= 1. Pixels already written are kept.
//  Timeout: counter runs while FSM is in S_B1/S_B2, cleared on every accepted byte; on reaching
//   TIMEOUT_CYC-1: drop group, address <= 0, FSM -> start state, err_sticky <= 1. No count in S_B0/S_SYNC.
//  rx_valid in the same cycle as timeout expiry: timeout wins, byte dropped.
//  Back-to-back rx_valid on consecutive cycles must be accepted without loss (one byte per cycle max).
//  Async reset mid-frame: immediate return to reset state; no mem_we glitch after rst deasserts.
// CONFIGURATION
//  PIXEL_LOADER_SYNC_EN defined: extra state S_SYNC; each frame begins only after byte 8'hA5 is received in
//   S_SYNC (address <= 0, -> S_B0); non-A5 bytes in S_SYNC ignored; after frame_done and after any rx_err or
//   timeout FSM returns to S_SYNC.
//  Not defined: no S_SYNC; FSM starts in S_B0, frames stream back-to-back, 8'hA5 is ordinary pixel data.
// STRUCTURE
//  Shared package pixel_pkg: RGB444 pixel typedef/width (12), SYNC_BYTE = 8'hA5, state encoding localparams.
//  Single module; no sub-module needed (timeout counter inline).
// TESTING
//  1. rst, then bytes 12,34,56 -> writes addr0=0x123, addr1=0x456; mem_we one cycle after each completing byte.
//  2. NUM_PIXELS=4 build: 6 bytes -> 4 writes at 0..3, frame_done with addr3 write, next byte writes addr 0.
//  3. bytes 12, rx_err, 34,56,78 -> err_sticky=1, single write addr0=0x345 then 0x678 at addr1.
//  4. byte 12 then idle TIMEOUT_CYC (set 16) cycles -> no write, err_sticky=1, next 3 bytes write from addr 0.
//  5. SYNC_EN: bytes 00,A5,AB,CD,EF -> 00 ignored, writes 0xABC@0, 0xDEF@1; without macro A5 becomes pixel data.
//  6. rst asserted between byte 2 and 3 -> outputs 0 immediately; later full group writes from addr 0.

Source files
------------

// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared pixel types, sync byte and loader state encoding
package pixel_pkg;

    localparam int PIXEL_W = 12;
    typedef logic [PIXEL_W-1:0] pixel_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        S_B0   = 2'd0,
        S_B1   = 2'd1,
        S_B2   = 2'd2,
        S_SYNC = 2'd3
    } state_t;

endpackage

// File: rtl/uart_pixel_loader.sv
// rtl/uart_pixel_loader.sv - packs UART bytes into RGB444 pixels and writes them to the frame BRAM
// Optional frame-start sync on byte A5 when PIXEL_LOADER_SYNC_EN is defined.
module uart_pixel_loader
    import pixel_pkg::*;
#(
    parameter int ADDR_W      = 17,
    parameter int NUM_PIXELS  = 76800,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [11:0]       mem_data,
    output logic              mem_we,
    output logic              frame_done,
    output logic              busy,
    output logic              err_sticky
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
`ifdef PIXEL_LOADER_SYNC_EN
    localparam state_t START = S_SYNC;
`else
    localparam state_t START = S_B0;
`endif

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         b0_q, b0_d;
    logic [3:0]         b1_lo_q, b1_lo_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    pixel_t             mem_data_q, mem_data_d;
    logic               mem_we_q, mem_we_d;
    logic               frame_done_q, frame_done_d;
    logic               err_q, err_d;

    logic               in_group;
    logic               tmo_hit;
    logic               wr;
    pixel_t             pix;

    assign in_group = (state_q == S_B1) || (state_q == S_B2);
    assign tmo_hit  = in_group && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        b0_d         = b0_q;
        b1_lo_d      = b1_lo_q;
        tmo_d        = in_group ? tmo_q + TMO_W'(1) : '0;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_we_d     = 1'b0;
        frame_done_d = 1'b0;
        err_d        = err_q;
        wr           = 1'b0;
        pix          = '0;

        // Timeout beats both rx_err and a byte arriving in the same cycle.
        if (tmo_hit) begin
            state_d = START;
            addr_d  = '0;
            err_d   = 1'b1;
            tmo_d   = '0;
        end else if (rx_err) begin
            state_d = START;
            err_d   = 1'b1;
            tmo_d   = '0;
        end else if (rx_valid) begin
            tmo_d = '0;
            case (state_q)
                S_B0: begin
                    b0_d    = rx_data;
                    state_d = S_B1;
                end
                S_B1: begin
                    b1_lo_d = rx_data[3:0];
                    wr      = 1'b1;
                    pix     = {b0_q, rx_data[7:4]};
                    state_d = S_B2;
                end
                S_B2: begin
                    wr      = 1'b1;
                    pix     = {b1_lo_q, rx_data};
                    state_d = S_B0;
                end
                default: begin
                    if (rx_data == SYNC_BYTE) begin
                        addr_d  = '0;
                        state_d = S_B0;
                    end
                end
            endcase
        end

        if (wr) begin
            mem_we_d   = 1'b1;
            mem_addr_d = addr_q;
            mem_data_d = pix;
            if (addr_q == LAST_ADDR) begin
                addr_d       = '0;
                frame_done_d = 1'b1;
`ifdef PIXEL_LOADER_SYNC_EN
                state_d      = S_SYNC;
`endif
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= START;
            addr_q       <= '0;
            b0_q         <= '0;
            b1_lo_q      <= '0;
            tmo_q        <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            b0_q         <= b0_d;
            b1_lo_q      <= b1_lo_d;
            tmo_q        <= tmo_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_we_q     <= mem_we_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign mem_we     = mem_we_q;
    assign frame_done = frame_done_q;
    assign err_sticky = err_q;
    assign busy       = (addr_q != '0) || in_group;

endmodule
